// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
// States, default count width and default clamp value.
package countdown_timer_pkg;

  localparam int CDT_DATA_WIDTH = 16;
  localparam int CDT_MAX        = 99;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cdt_state_t;

endpackage

// File: rtl/countdown_timer_rise_detect.sv
// One-flop rising-edge detector with synchronous active-low clear.
// Ports: clk, reset (active-low), sig in, rise out (sig & ~previous sig).
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_z;

  always_ff @(posedge clk) begin
    if (!reset) sig_z <= 1'b0;
    else        sig_z <= sig;
  end

  assign rise = sig & ~sig_z;

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counter with load/start/stop and a one-cycle expired pulse.
// Ports: clk, reset (sync active-low), load, load_value, start, stop -> count,
// running, expired. Define COUNTDOWN_TIMER_AUTORELOAD_EN for periodic reload.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int DATA_WIDTH = CDT_DATA_WIDTH,
  parameter int MAX        = CDT_MAX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  expired
);

  cdt_state_t            state, state_n;
  logic [DATA_WIDTH-1:0] reload, reload_n;
  logic [DATA_WIDTH-1:0] count_n, clamped;
  logic                  expired_n;
  logic                  start_rise, stop_rise;
  logic                  tick;

  rise_detect u_start_rd (
    .clk   (clk),
    .reset (reset),
    .sig   (start),
    .rise  (start_rise)
  );

  rise_detect u_stop_rd (
    .clk   (clk),
    .reset (reset),
    .sig   (stop),
    .rise  (stop_rise)
  );

  assign clamped = (load_value > DATA_WIDTH'(MAX))
                 ? DATA_WIDTH'(MAX) : load_value;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      reload  <= reload_n;
      expired <= expired_n;
    end
  end

  // tick: this edge consumes one count (running, or a start that
  // resumes from IDLE/PAUSE with something left to count).
  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload;
    expired_n = 1'b0;
    tick      = 1'b0;
    if (load) begin
      state_n  = IDLE;
      count_n  = clamped;
      reload_n = clamped;
    end else if (stop_rise) begin
      if (state == RUN) state_n = PAUSE;
    end else if (state == RUN) begin
      tick = 1'b1;
    end else if (start_rise && count != '0 &&
                 (state == IDLE || state == PAUSE)) begin
      tick = 1'b1;
    end
    if (tick) begin
      state_n = RUN;
      if (count == DATA_WIDTH'(1)) begin
        expired_n = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        count_n   = reload;
`else
        count_n   = '0;
        state_n   = DONE;
`endif
      end else begin
        count_n = count - DATA_WIDTH'(1);
      end
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios plus random stimulus
// against a behavioural model; a negedge monitor pops and compares expectations.
module tb_countdown_timer;

  localparam int W   = 16;
  localparam int MAX = 99;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] count;
  logic         running;
  logic         expired;

  countdown_timer #(.DATA_WIDTH(W), .MAX(MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .running    (running),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    bit          run;
    bit          exp;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, in plain terms
  int unsigned m_cnt = 0;
  int unsigned m_rel = 0;
  bit          m_run = 0;
  bit          m_fin = 0;
  bit          m_ps  = 0;
  bit          m_pp  = 0;

  function automatic exp_t model(bit r, bit l, int unsigned v,
                                 bit s, bit p, string tag);
    exp_t e;
    bit   sr, pr, ex;
    ex = 0;
    if (!r) begin
      m_cnt = 0; m_rel = 0; m_run = 0; m_fin = 0;
      m_ps = 0; m_pp = 0;
    end else begin
      sr = s && !m_ps;
      pr = p && !m_pp;
      m_ps = s;
      m_pp = p;
      if (l) begin
        m_cnt = (v > MAX) ? MAX : v;
        m_rel = m_cnt;
        m_run = 0;
        m_fin = 0;
      end else if (pr) begin
        m_run = 0;
      end else if (m_run || (sr && !m_fin && m_cnt > 0)) begin
        m_run = 1;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          ex = 1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          m_cnt = m_rel;
`else
          m_run = 0;
          m_fin = 1;
`endif
        end
      end
    end
    e.cnt = m_cnt;
    e.run = m_run;
    e.exp = ex;
    e.tag = tag;
    return e;
  endfunction

  task automatic step(bit r, bit l, int unsigned v, bit s, bit p,
                      string tag = "rand");
    exp_t e;
    reset      = r;
    load       = l;
    load_value = W'(v);
    start      = s;
    stop       = p;
    e = model(r, l, v, s, p, tag);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic hold(int n, string tag);
    for (int i = 0; i < n; i++) step(1, 0, 0, start, stop, tag);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (count !== W'(e.cnt)) begin
        n_fail++;
        $display("FAIL %s count: got %0d want %0d", e.tag, count, e.cnt);
      end
      n_checks++;
      if (running !== e.run) begin
        n_fail++;
        $display("FAIL %s running: got %b want %b", e.tag, running, e.run);
      end
      n_checks++;
      if (expired !== e.exp) begin
        n_fail++;
        $display("FAIL %s expired: got %b want %b", e.tag, expired, e.exp);
      end
    end
  end

  initial begin
    // reset with start held, then release: start edge with count 0
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "reset");
    step(1, 0, 0, 1, 0, "rst_release");
    step(1, 0, 0, 0, 0, "rst_idle");

    // one-shot from 5
    step(1, 1, 5, 0, 0, "load5");
    step(1, 0, 0, 1, 0, "start5");
    hold(6, "run5");
    step(1, 0, 0, 0, 0, "done5");
    step(1, 0, 0, 1, 0, "done_start");
    hold(3, "done_hold");

    // pause and resume
    step(1, 1, 10, 0, 0, "load10");
    step(1, 0, 0, 1, 0, "start10");
    step(1, 0, 0, 0, 0, "run10");
    step(1, 0, 0, 0, 0, "run10");
    step(1, 0, 0, 0, 1, "stop10");
    hold(20, "pause10");
    step(1, 0, 0, 1, 0, "resume10");
    hold(8, "run10b");

    // clamp, simultaneous start/stop
    step(1, 0, 0, 0, 0, "clr");
    step(1, 1, 250, 0, 0, "load250");
    step(1, 0, 0, 1, 1, "both");
    hold(3, "both_hold");

    // load mid-run
    step(1, 0, 0, 0, 0, "clr");
    step(1, 1, 6, 0, 0, "load6");
    step(1, 0, 0, 1, 0, "start6");
    hold(2, "run6");
    step(1, 1, 8, 1, 0, "reload8");
    hold(3, "idle8");

    // reset mid-run at count 2
    step(1, 0, 0, 0, 0, "clr");
    step(1, 0, 0, 1, 0, "start8");
    hold(5, "run8");
    step(0, 0, 0, 1, 0, "rst_mid");
    step(1, 0, 0, 0, 0, "after_rst");
    hold(3, "after_rst");

    // reload value 3 and 1
    step(1, 1, 3, 0, 0, "load3");
    step(1, 0, 0, 1, 0, "start3");
    hold(12, "run3");
    step(1, 1, 1, 0, 0, "load1");
    step(1, 0, 0, 0, 0, "clr");
    step(1, 0, 0, 1, 0, "start1");
    hold(5, "run1");

    // randomized
    for (int i = 0; i < 4000; i++) begin
      bit r, l, s, p;
      int unsigned v;
      r = ($urandom_range(0, 199) != 0);
      l = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) == 0) ? 32'hFFFF :
          ($urandom_range(0, 1) ? $urandom_range(0, 12)
                                : $urandom_range(0, 300));
      s = ($urandom_range(0, 7) == 0) ? ~start : start;
      p = ($urandom_range(0, 15) == 0) ? ~stop : stop;
      step(r, l, v, s, p);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
